ksm_term: RTL
=============

# ksm_term

Character-stream terminal engine for the KSM text console. It accepts bytes from the serial receiver, interprets a small control set, and writes characters into the VGA adapter's video RAM as a Wishbone master. It scrolls and clears the 24-line working area, which occupies screen rows 1..24. Row 0 is the service line and is never touched. The block also drives the adapter's `cursor`, `cursor_on`, `cursor_type` and `flash` inputs.

## Interface
- `COLS`, 80: characters per row.
- `ROWS`, 24: rows in the working area.
- `BASE`, 80: character address of working-area row 0.
- `FLASH_DIV`, 25000000: clock cycles per `flash_o` half-period.

- `wb_clk_i`  in  1  single clock for the whole block.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `char_i`  in  8  input byte.
- `char_valid_i`  in  1  byte available.
- `char_ready_o`  out  1  byte accepted when `char_valid_i & char_ready_o` at a rising edge.
- `wbm_adr_o`  out  16  byte address = {4'b0, char_addr[11:0]}.
- `wbm_dat_o`  out  16  write data.
- `wbm_dat_i`  in  16  read data.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1  classic Wishbone cycle.
- `wbm_sel_o`  out  2  byte lanes.
- `wbm_ack_i`  in  1  slave acknowledge.
- `cursor_o`  out  13  `BASE + row*COLS + col`.
- `cursor_on_o`  out  1  cursor visible.
- `cursor_type_o`  out  1  constant 0 (underline).
- `flash_o`  out  1  blink square wave.

## Operation
- The cursor position is held as `col` (0..COLS-1) and `row` (0..ROWS-1). `cursor_o` is a registered function of the two.
- FSM states:
  - IDLE: `char_ready_o`=1.
  - WRITE: single character write.
  - SCR_RD, SCR_WR: scroll copy.
  - CLR_WR: fill with spaces.
- Decoding of an accepted byte in IDLE:
  - ESC flag set: write the byte literally. This is how codes 00-1F, which the adapter displays as flashing characters, are placed. The flag is cleared.
  - 0x1B: set the ESC flag. No bus cycle.
  - 0x0D CR: `col`=0.
  - 0x0A LF: if `row`<ROWS-1, `row`+1; otherwise scroll.
  - 0x08 BS: `col`-1 if `col`>0; at `col`=0, no effect.
  - 0x0C FF: clear the working area, then cursor home.
  - Any other byte below 0x20: consumed and ignored.
  - Bytes 0x20..0xFF: go to WRITE.
- WRITE issues one bus cycle:
  - `we`=1.
  - `dat`={b,b}.
  - `sel`=`addr[0]` ? 2'b10 : 2'b01.
  - After the ack, `col`+1. At `col`=COLS-1 the cursor wraps to `col`=0 and advances the row, following the same rule as LF (scroll on the last row).
- Scroll:
  - For each word w in 0..(ROWS-1)*COLS/2-1: read from byte address `BASE+COLS+2w` (SCR_RD), then write that data with `sel`=11 to `BASE+2w` (SCR_WR).
  - Then CLR_WR writes 0x2020 with `sel`=11 over the COLS/2 words of the last row.
  - `row` stays at ROWS-1.
- Clear: CLR_WR writes 0x2020 to all ROWS*COLS/2 words from `BASE`, then `row`=`col`=0.
- `cursor_on_o`=0 while in SCR_RD, SCR_WR or CLR_WR; 1 otherwise.
- `flash_o` toggles every FLASH_DIV cycles.

## Timing
- Reset values:
  - `char_ready_o`=1.
  - `wbm_cyc_o`=`wbm_stb_o`=`wbm_we_o`=0, `wbm_sel_o`=0, `wbm_adr_o`=0, `wbm_dat_o`=0.
  - `row`=`col`=0, so `cursor_o`=80.
  - `cursor_on_o`=1, `cursor_type_o`=0, `flash_o`=0.
  - ESC flag clear, flash counter 0.
- Reset mid-operation aborts the cycle: cyc and stb drop asynchronously. Video RAM is left partially updated, which is acceptable.
- Non-writing controls (CR, BS, LF without scroll, ESC prefix, ignored bytes) complete at the accept edge. `char_ready_o` stays 1 and the updated `cursor_o` is visible the next cycle, so throughput is one byte per clock.
- Printable byte accepted at edge T:
  - `char_ready_o` is 0 and cyc/stb are 1 from T.
  - With the adapter's 1-cycle ack, `wbm_ack_i`=1 in cycle T+2.
  - At edge T+3: cyc/stb drop, `cursor_o` is updated, and `char_ready_o`=1 unless a scroll follows.
- Each bus cycle:
  - Outputs are registered and held stable until the ack is sampled.
  - cyc/stb are deasserted for at least one cycle between bus cycles.
  - Read data is captured on the ack edge.
- A scroll or clear holds `char_ready_o`=0 until the final ack, then returns to IDLE.

## Structure
- Package `ksm_term_pkg`: control codes (CR, LF, BS, FF, ESC, SPACE), the FSM state enum, and default geometry constants.
- Sub-module `ksm_flash_div`: FLASH_DIV counter plus toggle flop, instantiated once.

## Test plan
- Reset, send 0x41 → one write with adr=0x0050, sel=01, dat=0x4141; `cursor_o` goes 80→81; `char_ready_o` low for exactly 3 cycles.
- Send 0x42, then 0x0D → write with adr=0x0050, sel=10; the CR produces no bus cycle and `cursor_o`=80 the next cycle; a 0x08 at `col`=0 leaves `cursor_o` unchanged.
- Send 0x05 → no bus cycle, cursor unchanged. Send 0x1B, 0x05 → write with dat=0x0505 at the cursor, cursor +1.
- Place the cursor at `row`=23, send 80 printable bytes → after the 80th write:
  - 920 read/write pairs, with reads from 0x00A0 upward and writes to 0x0050 upward;
  - 40 writes of 0x2020 at 0x0780..0x07CE;
  - `cursor_o`=1920 and `cursor_on_o`=0 throughout.
- Send 0x0C → 960 writes of 0x2020 at 0x0050..0x07CE, then `cursor_o`=80; a byte offered mid-clear is not accepted until the clear is done.
- Assert `wb_rst_i` mid-scroll → cyc and stb low in the same cycle, `cursor_o`=80. With FLASH_DIV=4, `flash_o` toggles every 4 cycles after the reset is released.

Source files
------------

// File: rtl/ksm_term_pkg.sv
// ksm_term shared definitions: control codes, FSM states,
// default console geometry.
package ksm_term_pkg;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam int DEF_COLS      = 80;
  localparam int DEF_ROWS      = 24;
  localparam int DEF_BASE      = 80;
  localparam int DEF_FLASH_DIV = 25000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_CLR_WR
  } state_t;

endpackage

// File: rtl/ksm_flash_div.sv
// Blink generator: square wave that toggles
// once every DIV clock cycles.
module ksm_flash_div #(
  parameter int DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  output logic flash
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      flash <= 1'b0;
    end else if (cnt == W'(DIV - 1)) begin
      cnt   <= '0;
      flash <= ~flash;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ksm_term.sv
// KSM console terminal engine: byte stream in,
// Wishbone writes into the adapter's video RAM.
module ksm_term
  import ksm_term_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS      = DEF_ROWS,
  parameter int BASE      = DEF_BASE,
  parameter int FLASH_DIV = DEF_FLASH_DIV
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  char_i,
  input  logic        char_valid_i,
  output logic        char_ready_o,
  output logic [15:0] wbm_adr_o,
  output logic [15:0] wbm_dat_o,
  input  logic [15:0] wbm_dat_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [1:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  output logic [12:0] cursor_o,
  output logic        cursor_on_o,
  output logic        cursor_type_o,
  output logic        flash_o
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  localparam logic [11:0] BASE_A  = 12'(BASE);
  localparam logic [11:0] COLS_A  = 12'(COLS);
  localparam logic [11:0] SCR_END = 12'(BASE + (ROWS - 1) * COLS - 2);
  localparam logic [11:0] CLR_END = 12'(BASE + ROWS * COLS - 2);
  localparam logic [12:0] BASE_C  = 13'(BASE);
  localparam logic [12:0] COLS_C  = 13'(COLS);
  localparam logic [12:0] WRAP_C  = 13'(COLS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

  state_t        state, state_n;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [11:0]   ptr;
  logic          esc, home;
  logic          acc, ack, last_col, last_row;
  logic          lit;

  assign acc      = char_valid_i & char_ready_o;
  assign ack      = wbm_ack_i & wbm_cyc_o;
  assign last_col = (col == COL_MAX);
  assign last_row = (row == ROW_MAX);
  assign lit      = esc | (char_i >= CH_SPACE);

  assign cursor_type_o = 1'b0;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (acc) begin
          if (lit)
            state_n = ST_WRITE;
          else if (char_i == CH_LF && last_row)
            state_n = ST_SCR_RD;
          else if (char_i == CH_FF)
            state_n = ST_CLR_WR;
        end
      end
      ST_WRITE:
        if (ack)
          state_n = (last_col && last_row) ? ST_SCR_RD : ST_IDLE;
      ST_SCR_RD:
        if (ack) state_n = ST_SCR_WR;
      ST_SCR_WR:
        if (ack) state_n = (ptr == SCR_END) ? ST_CLR_WR : ST_SCR_RD;
      ST_CLR_WR:
        if (ack && ptr == CLR_END) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    char_ready_o = (state == ST_IDLE);
    cursor_on_o  = !(state inside {ST_SCR_RD, ST_SCR_WR, ST_CLR_WR});
  end

  // ptr walks the destination word; a scroll falls through into
  // the last-row clear because ptr+2 then lands on that row.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 2'b00;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      col       <= '0;
      row       <= '0;
      cursor_o  <= BASE_C;
      ptr       <= '0;
      esc       <= 1'b0;
      home      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (acc && lit) begin
            esc       <= 1'b0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_adr_o <= {4'b0, cursor_o[11:1], 1'b0};
            wbm_sel_o <= cursor_o[0] ? 2'b10 : 2'b01;
            wbm_dat_o <= {char_i, char_i};
          end else if (acc) begin
            case (char_i)
              CH_ESC: esc <= 1'b1;
              CH_CR: begin
                col      <= '0;
                cursor_o <= cursor_o - 13'(col);
              end
              CH_LF: begin
                if (!last_row) begin
                  row      <= row + 1'b1;
                  cursor_o <= cursor_o + COLS_C;
                end else begin
                  ptr <= BASE_A;
                end
              end
              CH_BS: begin
                if (col != '0) begin
                  col      <= col - 1'b1;
                  cursor_o <= cursor_o - 1'b1;
                end
              end
              CH_FF: begin
                ptr  <= BASE_A;
                home <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_WRITE: begin
          if (ack) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            if (!last_col) begin
              col      <= col + 1'b1;
              cursor_o <= cursor_o + 1'b1;
            end else begin
              col <= '0;
              if (!last_row) begin
                row      <= row + 1'b1;
                cursor_o <= cursor_o + 1'b1;
              end else begin
                cursor_o <= cursor_o - WRAP_C;
                ptr      <= BASE_A;
              end
            end
          end
        end
        ST_SCR_RD: begin
          if (!wbm_cyc_o) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= {4'b0, ptr + COLS_A};
            wbm_sel_o <= 2'b11;
          end else if (ack) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_dat_o <= wbm_dat_i;
          end
        end
        ST_SCR_WR: begin
          if (!wbm_cyc_o) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_adr_o <= {4'b0, ptr};
            wbm_sel_o <= 2'b11;
          end else if (ack) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            ptr       <= ptr + 12'd2;
          end
        end
        ST_CLR_WR: begin
          if (!wbm_cyc_o) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_adr_o <= {4'b0, ptr};
            wbm_sel_o <= 2'b11;
            wbm_dat_o <= {CH_SPACE, CH_SPACE};
          end else if (ack) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            if (ptr != CLR_END) begin
              ptr <= ptr + 12'd2;
            end else if (home) begin
              home     <= 1'b0;
              row      <= '0;
              col      <= '0;
              cursor_o <= BASE_C;
            end
          end
        end
        default: ;
      endcase
    end
  end

  ksm_flash_div #(
    .DIV(FLASH_DIV)
  ) u_flash (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .flash(flash_o)
  );

endmodule
